// File: rtl/updn_mod_counter.sv
// Synchronous up/down modulo counter with enable, parallel load and terminal count.
// Define UPDN_COUNT_SAT_EN to saturate at the bounds instead of wrapping.
module updn_mod_counter #(
  parameter int unsigned     WIDTH = 4,
  parameter longint unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam longint unsigned SPAN = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 64'd1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updn_mod_counter: WIDTH must be 1..32");
  end
  if (MOD < 2 || MOD > SPAN) begin : g_bad_mod
    $error("updn_mod_counter: MOD must be 2..2**WIDTH");
  end

  logic             at_top;
  logic             at_bot;
  logic             over;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] q_next;

  assign at_top = (q == TOP);
  assign at_bot = (q == '0);
  // q beyond MOD-1 is unreachable normally; treat it like the wrap point
  assign over   = (64'(q) >= MOD);

  assign load_clamped = (64'(load_val) >= MOD) ? TOP : load_val;

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_clamped;
    end else if (en) begin
      if (up_dn) begin
`ifdef UPDN_COUNT_SAT_EN
        if (at_top || over) q_next = TOP;
        else                q_next = q + WIDTH'(1);
`else
        if (at_top || over) q_next = '0;
        else                q_next = q + WIDTH'(1);
`endif
      end else begin
`ifdef UPDN_COUNT_SAT_EN
        if (at_bot)    q_next = '0;
        else if (over) q_next = TOP;
        else           q_next = q - WIDTH'(1);
`else
        if (at_bot || over) q_next = TOP;
        else                q_next = q - WIDTH'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

  // rst gating keeps tc low while q is forced to 0 with up_dn=0
  assign tc = ~rst & en & ~load & ((up_dn & at_top) | (~up_dn & at_bot));

endmodule

// File: tb/tb_updn_mod_counter.sv
// Self-checking bench for updn_mod_counter: MOD=16, MOD=10 and a MOD=10 cascade stage.
module tb_updn_mod_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q16, q10, qc;
  logic       tc16, tc10, tcc;

  int total = 0;
  int bad   = 0;
  int m16, m10, mc;

  updn_mod_counter #(.WIDTH(4), .MOD(16)) u16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q16), .tc(tc16));

  updn_mod_counter #(.WIDTH(4), .MOD(10)) u10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q10), .tc(tc10));

  updn_mod_counter #(.WIDTH(4), .MOD(10)) uc (
    .clk(clk), .rst(rst), .en(tc10), .up_dn(1'b1), .load(1'b0),
    .load_val(4'd0), .q(qc), .tc(tcc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain integer arithmetic on the specified rules
  function automatic int next_q(int q, int m, bit e, bit u, bit l, int v);
    if (l) return (v >= m) ? m - 1 : v;
    if (!e) return q;
`ifdef UPDN_COUNT_SAT_EN
    if (u) return (q >= m - 1) ? m - 1 : q + 1;
    return (q == 0) ? 0 : q - 1;
`else
    if (u) return (q + 1) % m;
    return (q + m - 1) % m;
`endif
  endfunction

  function automatic bit tc_of(int q, int m, bit e, bit u, bit l);
    return e && !l && (u ? (q == m - 1) : (q == 0));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit e, input bit u, input bit l, input logic [3:0] v);
    bit t10;
    en = e; up_dn = u; load = l; load_val = v;
    #1;
    t10 = tc_of(m10, 10, e, u, l);
    chk("tc16", 32'(tc16), 32'(tc_of(m16, 16, e, u, l)));
    chk("tc10", 32'(tc10), 32'(t10));
    chk("tcc",  32'(tcc),  32'(tc_of(mc, 10, t10, 1'b1, 1'b0)));
    @(posedge clk);
    m16 = next_q(m16, 16, e, u, l, int'(v));
    m10 = next_q(m10, 10, e, u, l, int'(v));
    mc  = next_q(mc, 10, t10, 1'b1, 1'b0, 0);
    #1;
    chk("q16", 32'(q16), 32'(m16));
    chk("q10", 32'(q10), 32'(m10));
    chk("qc",  32'(qc),  32'(mc));
  endtask

  // asynchronous reset pulse between clock edges
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_q16", 32'(q16), 32'd0);
    chk("rst_q10", 32'(q10), 32'd0);
    chk("rst_qc",  32'(qc),  32'd0);
    chk("rst_tc16", 32'(tc16), 32'd0);
    chk("rst_tc10", 32'(tc10), 32'd0);
    m16 = 0; m10 = 0; mc = 0;
    #2;
    rst = 1'b0;
  endtask

  int flip_exp[7] = '{6, 7, 6, 6, 6, 6, 5};
  int c0;

  initial begin
    rst = 1'b1; en = 1'b1; up_dn = 1'b0; load = 1'b0; load_val = 4'd0;
    m16 = 0; m10 = 0; mc = 0;
    @(posedge clk);
    #1;
    chk("init_q16", 32'(q16), 32'd0);
    chk("init_tc16", 32'(tc16), 32'd0);
    rst = 1'b0;
    en = 1'b0;

    // q=9, then async reset mid-cycle with en=1/up_dn=0 driven
    step(1'b1, 1'b0, 1'b1, 4'd9);
    chk("pre_rst_q16", 32'(q16), 32'd9);
    en = 1'b1; up_dn = 1'b0;
    pulse_reset();

    // legacy down sequence 15..0,15
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0);
      chk("down_seq", 32'(q16), 32'((i < 16) ? 15 - i : 15));
    end

    // up count MOD=10 with cascade
    step(1'b1, 1'b1, 1'b1, 4'd0);
    c0 = mc;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0);
      chk("up10_seq", 32'(q10), 32'((i + 1) % 10));
    end
`ifdef UPDN_COUNT_SAT_EN
    chk("cascade", 32'(qc), 32'((c0 + 2 > 9) ? 9 : c0 + 2));
`else
    chk("cascade", 32'(qc), 32'((c0 + 2) % 10));
`endif

    // load priority and clamp
    en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd7;
    #1;
    chk("load_tc10", 32'(tc10), 32'd0);
    step(1'b1, 1'b1, 1'b1, 4'd7);
    chk("load7", 32'(q10), 32'd7);
    step(1'b1, 1'b0, 1'b1, 4'd12);
    chk("clamp12", 32'(q10), 32'd9);
    chk("noclamp16", 32'(q16), 32'd12);

    // direction flip and hold with up_dn toggling
    step(1'b0, 1'b0, 1'b1, 4'd5);
    step(1'b1, 1'b1, 1'b0, 4'd0); chk("flip0", 32'(q10), 32'(flip_exp[0]));
    step(1'b1, 1'b1, 1'b0, 4'd0); chk("flip1", 32'(q10), 32'(flip_exp[1]));
    step(1'b1, 1'b0, 1'b0, 4'd0); chk("flip2", 32'(q10), 32'(flip_exp[2]));
    step(1'b0, 1'b1, 1'b0, 4'd0); chk("flip3", 32'(q10), 32'(flip_exp[3]));
    step(1'b0, 1'b0, 1'b0, 4'd0); chk("flip4", 32'(q10), 32'(flip_exp[4]));
    step(1'b0, 1'b1, 1'b0, 4'd0); chk("flip5", 32'(q10), 32'(flip_exp[5]));
    step(1'b1, 1'b0, 1'b0, 4'd0); chk("flip6", 32'(q10), 32'(flip_exp[6]));

    // behaviour at the bounds: saturate or wrap depending on build
    step(1'b0, 1'b1, 1'b1, 4'd14);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0);
`ifdef UPDN_COUNT_SAT_EN
      chk("sat_up", 32'(q16), 32'd15);
`else
      chk("wrap_up", 32'(q16), 32'((15 + i) % 16));
`endif
    end
    step(1'b0, 1'b0, 1'b1, 4'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0);
`ifdef UPDN_COUNT_SAT_EN
      chk("sat_dn", 32'(q16), 32'd0);
`else
      chk("wrap_dn", 32'(q16), 32'((i == 0) ? 0 : 15));
`endif
    end

    // randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulse_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
